// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned d = a - b, LSB first, one bit per clock over WIDTH cycles.
// Define SERIAL_SUB_OVERFLOW_EN to add the two's-complement overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb, res, res_nx;
  logic [CW-1:0] cnt;
  logic br, dbit, nb, last, accept;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    last = cnt == CW'(WIDTH - 1);
    state_nx = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  // Diff bit enters at the MSB so that after WIDTH shifts bit i lands at position i.
  always_comb begin
    dbit = sa[0] ^ sb[0] ^ br;
    nb = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_nx = WIDTH'({dbit, res} >> 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      res <= '0;
      cnt <= '0;
      br <= 1'b0;
      d <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf <= 1'b0;
`endif
    end else if (accept) begin
      sa <= a;
      sb <= b;
      res <= '0;
      cnt <= '0;
      br <= 1'b0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      res <= res_nx;
      cnt <= cnt + 1'b1;
      br <= nb;
      if (last) begin
        d <= res_nx;
        bout <= nb;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf <= br ^ nb;
`endif
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive checks of serial_subtractor at WIDTH = 4.
// Checks ovf too when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic busy, done, bout;
  logic [3:0] d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf;
`endif
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .bout(bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  // Reference adder built from half-adder cells: returns {cout, sum}.
  function automatic logic [4:0] ha_add(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] s;
    logic c, s1, c1, c2;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s1 = x[i] ^ y[i];
      c1 = x[i] & y[i];
      s[i] = s1 ^ c;
      c2 = s1 & c;
      c = c1 | c2;
    end
    return {c, s};
  endfunction
  // Starts one op from a negedge and follows it to done and one cycle beyond.
  task automatic run_op(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] ed, input logic eb, input logic full);
    logic [3:0] prev;
    int k;
    logic [4:0] sum;
    prev = d;
    a = x;
    b = y;
    start = 1'b1;
    cyc();
    start = 1'b0;
    a = 4'hf;
    b = 4'h0;
    if (full) chk({tag, "_busy0"}, busy, 1);
    k = 0;
    while (!done && k < 10) begin
      if (full) chk({tag, "_hold"}, d, prev);
      cyc();
      k++;
    end
    if (full) chk({tag, "_lat"}, k, 4);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_d"}, d, ed);
    chk({tag, "_bout"}, bout, eb);
    sum = ha_add(d, y);
    if (!full) chk({tag, "_adder"}, sum, {bout, x});
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk({tag, "_ovf"}, ovf, (x[3] != y[3]) && (ed[3] != x[3]));
`endif
    if (full) chk({tag, "_busy_done"}, busy, 0);
    cyc();
    if (full) chk({tag, "_done_low"}, done, 0);
    if (full) chk({tag, "_d_kept"}, d, ed);
  endtask
  initial begin
    #12;
    chk("rst_init_busy", busy, 0);
    chk("rst_init_d", d, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    run_op("sub_7_3", 4'b0111, 4'b0011, 4'b0100, 1'b0, 1'b1);
    cyc();
    chk("sub_7_3_held", d, 4'b0100);
    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_d", d, 0);
    chk("async_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    run_op("sub_1_15", 4'b0001, 4'b1111, 4'b0010, 1'b1, 1'b1);
    run_op("sub_0_1", 4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b1);
    run_op("sub_15_15", 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1);
    run_op("sub_7_15", 4'b0111, 4'b1111, 4'b1000, 1'b1, 1'b1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf_7_15", ovf, 1);
`endif
    run_op("sub_8_1", 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf_8_1", ovf, 1);
`endif
    run_op("sub_3_1", 4'b0011, 4'b0001, 4'b0010, 1'b0, 1'b1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf_3_1", ovf, 0);
`endif
    // start while busy must be ignored
    a = 4'b0110;
    b = 4'b0001;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    a = 4'b1111;
    b = 4'b1111;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("ign_busy", busy, 1);
    cyc();
    chk("ign_pre_done", done, 0);
    cyc();
    chk("ign_done", done, 1);
    chk("ign_d", d, 4'b0101);
    chk("ign_bout", bout, 0);
    cyc();
    chk("ign_single", done, 0);
    chk("ign_idle", busy, 0);
    // back-to-back: start held during the DONE cycle
    a = 4'b1001;
    b = 4'b0010;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    cyc();
    chk("b2b_first_done", done, 1);
    chk("b2b_first_d", d, 4'b0111);
    a = 4'b0011;
    b = 4'b0101;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("b2b_no_idle", busy, 1);
    cyc();
    cyc();
    cyc();
    chk("b2b_pre_done", done, 0);
    chk("b2b_d_hold", d, 4'b0111);
    cyc();
    chk("b2b_done", done, 1);
    chk("b2b_d", d, 4'b1110);
    chk("b2b_bout", bout, 1);
    cyc();
    // reset in the middle of RUN
    a = 4'b1001;
    b = 4'b0100;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_d", d, 0);
    chk("mid_rst_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_no_done", done, 0);
      cyc();
    end
    run_op("after_rst", 4'b1001, 4'b0100, 4'b0101, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op("exh", 4'(i), 4'(j), 4'(i - j), i < j, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
